// File: rtl/params_pkg.sv
// Shared types and constants for the EX-stage multiply pipeline.
//
// Contents:
//   DATA_WIDTH / REGISTER_WIDTH / ADDR_WIDTH  default datapath widths
//   MUL_MAX_STAGES                            deepest legal pipeline
//   instruction_t                             raw instruction word (debug trace)
//   mul_mode_e                                product-half selection
//   mul_stage_t                               contents of one pipeline register
//   mul_a_signed / mul_b_signed               operand signedness per mode
//
// Optional feature macro: MUL_DEBUG_TRACE_EN adds debug PC/instruction fields
// to mul_stage_t.
package params_pkg;

  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned REGISTER_WIDTH = 5;
  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned MUL_MAX_STAGES = 8;

  typedef logic [31:0] instruction_t;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,  // low half, MUL
    MUL_HSS = 2'b01,  // high half, signed x signed, MULH
    MUL_HSU = 2'b10,  // high half, signed x unsigned, MULHSU
    MUL_HUU = 2'b11   // high half, unsigned x unsigned, MULHU
  } mul_mode_e;

  typedef struct packed {
    logic                      valid;
    logic [REGISTER_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0]     result;
`ifdef MUL_DEBUG_TRACE_EN
    logic [ADDR_WIDTH-1:0]     debug_pc;
    instruction_t              debug_instr;
`endif
  } mul_stage_t;

  function automatic logic mul_a_signed(input mul_mode_e mode);
    return (mode == MUL_HSS) || (mode == MUL_HSU);
  endfunction

  function automatic logic mul_b_signed(input mul_mode_e mode);
    return (mode == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Issue / control / result bundle between the EX-stage issuer, the multiply
// pipeline and the writeback arbiter.
//
// Issue side : valid_i, mode_i, a_i, b_i, wr_reg_i
// Control    : stall_i, flush_i, check_reg_i
// Status     : hazard_o, busy_o, wb_is_next_cycle_o
// Result     : result_valid_o, result_o, wr_reg_o
// Debug      : debug_pc_i/o, debug_instr_i/o (only with MUL_DEBUG_TRACE_EN)
//
// Modports: master = issuer/consumer side, slave = mul_pipe.
interface mul_pipe_if #(
  parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int unsigned ADDR_WIDTH     = params_pkg::ADDR_WIDTH
) ();

  logic                      valid_i;
  params_pkg::mul_mode_e     mode_i;
  logic [DATA_WIDTH-1:0]     a_i;
  logic [DATA_WIDTH-1:0]     b_i;
  logic [REGISTER_WIDTH-1:0] wr_reg_i;
  logic                      stall_i;
  logic                      flush_i;
  logic [REGISTER_WIDTH-1:0] check_reg_i;
  logic                      hazard_o;
  logic                      busy_o;
  logic                      wb_is_next_cycle_o;
  logic                      result_valid_o;
  logic [DATA_WIDTH-1:0]     result_o;
  logic [REGISTER_WIDTH-1:0] wr_reg_o;
`ifdef MUL_DEBUG_TRACE_EN
  logic [ADDR_WIDTH-1:0]     debug_pc_i;
  params_pkg::instruction_t  debug_instr_i;
  logic [ADDR_WIDTH-1:0]     debug_pc_o;
  params_pkg::instruction_t  debug_instr_o;
`endif

  modport master (
    output valid_i, mode_i, a_i, b_i, wr_reg_i, stall_i, flush_i, check_reg_i,
`ifdef MUL_DEBUG_TRACE_EN
    output debug_pc_i, debug_instr_i,
    input  debug_pc_o, debug_instr_o,
`endif
    input  hazard_o, busy_o, wb_is_next_cycle_o, result_valid_o, result_o, wr_reg_o
  );

  modport slave (
    input  valid_i, mode_i, a_i, b_i, wr_reg_i, stall_i, flush_i, check_reg_i,
`ifdef MUL_DEBUG_TRACE_EN
    input  debug_pc_i, debug_instr_i,
    output debug_pc_o, debug_instr_o,
`endif
    output hazard_o, busy_o, wb_is_next_cycle_o, result_valid_o, result_o, wr_reg_o
  );

endinterface

// File: rtl/mul_pipe_stage.sv
// One pipeline register of the multiply pipeline.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset, clears the whole register
//   stall_i  hold current contents
//   flush_i  clear the valid bit (wins over stall_i)
//   stage_i  contents offered by the previous stage / front end
//   stage_o  registered contents
//
// Optional feature macro: MUL_DEBUG_TRACE_EN (widens mul_stage_t only).
module mul_pipe_stage
  import params_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       stall_i,
  input  logic       flush_i,
  input  mul_stage_t stage_i,
  output mul_stage_t stage_o
);

  mul_stage_t stage_d;
  mul_stage_t stage_q;

  // Flush only kills the valid bit; payload of an invalid stage is don't-care.
  always_comb begin
    stage_d = stage_q;
    if (flush_i) begin
      stage_d.valid = 1'b0;
    end else if (!stall_i) begin
      stage_d = stage_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/mul_pipe.sv
// Parametrised integer multiply pipeline for the EX stage. A single front-end
// multiply selects the product half for the requested mode; the result then
// travels through NUM_STAGES registers before being presented to writeback.
//
// Parameters:
//   NUM_STAGES      pipeline registers from issue to result output (2..8)
//   DATA_WIDTH      operand/result width
//   REGISTER_WIDTH  destination register index width
//   ADDR_WIDTH      debug PC width
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     mul_pipe_if slave: issue, stall/flush, hazard query, status, result
//
// Optional feature macro: MUL_DEBUG_TRACE_EN carries debug PC and instruction
// alongside each op, aligned with result_o.
module mul_pipe
  import params_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned DATA_WIDTH     = params_pkg::DATA_WIDTH,
  parameter int unsigned REGISTER_WIDTH = params_pkg::REGISTER_WIDTH,
  parameter int unsigned ADDR_WIDTH     = params_pkg::ADDR_WIDTH
) (
  input logic       clk_i,
  input logic       rst_ni,
  mul_pipe_if.slave bus
);

  if (NUM_STAGES < 2 || NUM_STAGES > MUL_MAX_STAGES) begin : g_bad_depth
    $error("mul_pipe: NUM_STAGES=%0d outside legal range 2..%0d",
           NUM_STAGES, MUL_MAX_STAGES);
  end

  // The stage register layout comes from the package, so the datapath widths
  // must agree with it.
  if (DATA_WIDTH != params_pkg::DATA_WIDTH ||
      REGISTER_WIDTH != params_pkg::REGISTER_WIDTH ||
      ADDR_WIDTH != params_pkg::ADDR_WIDTH) begin : g_bad_width
    $error("mul_pipe: width parameters must match params_pkg");
  end

  logic                    a_ext_msb;
  logic                    b_ext_msb;
  logic [2*DATA_WIDTH-1:0] a_wide;
  logic [2*DATA_WIDTH-1:0] b_wide;
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   result_sel;

  // Each operand is conceptually extended to DATA_WIDTH+1 bits (bit DATA_WIDTH
  // is the sign for signed modes, 0 otherwise) and multiplied as signed.
  // Only the low 2*DATA_WIDTH product bits are ever used, so the extension bit
  // is simply replicated up to 2*DATA_WIDTH and the low half of that product
  // is identical to the signed (DATA_WIDTH+1)-bit product.
  always_comb begin
    a_ext_msb  = mul_a_signed(bus.mode_i) & bus.a_i[DATA_WIDTH-1];
    b_ext_msb  = mul_b_signed(bus.mode_i) & bus.b_i[DATA_WIDTH-1];
    a_wide     = {{DATA_WIDTH{a_ext_msb}}, bus.a_i};
    b_wide     = {{DATA_WIDTH{b_ext_msb}}, bus.b_i};
    product    = a_wide * b_wide;
    result_sel = product[2*DATA_WIDTH-1:DATA_WIDTH];
    if (bus.mode_i == MUL_LO) begin
      result_sel = product[DATA_WIDTH-1:0];
    end
  end

  mul_stage_t issue_s;

  always_comb begin
    issue_s             = '0;
    issue_s.valid       = bus.valid_i;
    issue_s.wr_reg      = bus.wr_reg_i;
    issue_s.result      = result_sel;
`ifdef MUL_DEBUG_TRACE_EN
    issue_s.debug_pc    = bus.debug_pc_i;
    issue_s.debug_instr = bus.debug_instr_i;
`endif
  end

  mul_stage_t stage_q [NUM_STAGES];

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    mul_stage_t stage_in;
    if (i == 0) begin : g_first
      assign stage_in = issue_s;
    end else begin : g_next
      assign stage_in = stage_q[i-1];
    end

    mul_pipe_stage u_stage (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .stall_i (bus.stall_i),
      .flush_i (bus.flush_i),
      .stage_i (stage_in),
      .stage_o (stage_q[i])
    );
  end

  logic any_valid;
  logic reg_match;

  // The output stage still counts: its result has not been written back yet.
  always_comb begin
    any_valid = 1'b0;
    reg_match = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      any_valid = any_valid | stage_q[i].valid;
      if (stage_q[i].valid && (stage_q[i].wr_reg == bus.check_reg_i)) begin
        reg_match = 1'b1;
      end
    end
  end

  assign bus.hazard_o           = reg_match & (bus.check_reg_i != '0);
  assign bus.busy_o             = any_valid;
  assign bus.wb_is_next_cycle_o = stage_q[NUM_STAGES-2].valid & ~bus.stall_i & ~bus.flush_i;
  assign bus.result_valid_o     = stage_q[NUM_STAGES-1].valid;
  assign bus.result_o           = stage_q[NUM_STAGES-1].result;
  assign bus.wr_reg_o           = stage_q[NUM_STAGES-1].wr_reg;
`ifdef MUL_DEBUG_TRACE_EN
  assign bus.debug_pc_o         = stage_q[NUM_STAGES-1].debug_pc;
  assign bus.debug_instr_o      = stage_q[NUM_STAGES-1].debug_instr;
`endif

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, self-registering integer multiply pipeline. It succeeds the fixed five-stage pass-through EX chain.
- Owns its stage registers and supports a configurable depth (NUM_STAGES).
- Supports MUL/MULH/MULHSU/MULHU modes, global stall, and flush.
- Provides an in-flight destination scoreboard for hazard detection.
- Sits beside the ALU in the EX stage and feeds the writeback arbiter.

Parameters:
- NUM_STAGES, 5, number of pipeline registers from issue to result output; legal range 2..8.
- DATA_WIDTH, params_pkg::DATA_WIDTH, operand/result width.
- REGISTER_WIDTH, params_pkg::REGISTER_WIDTH, destination register index width.
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, debug PC width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- valid_i  in  1  issue request
- mode_i  in  mul_mode_e (2)  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- a_i  in  DATA_WIDTH  operand rs1
- b_i  in  DATA_WIDTH  operand rs2
- wr_reg_i  in  REGISTER_WIDTH  destination register
- stall_i  in  1  freeze all stages
- flush_i  in  1  kill all in-flight ops
- check_reg_i  in  REGISTER_WIDTH  source register to test for hazard
- hazard_o  out  1  check_reg_i matches a valid in-flight destination
- busy_o  out  1  any stage valid
- wb_is_next_cycle_o  out  1  result_valid_o will rise next cycle
- result_valid_o  out  1  result available
- result_o  out  DATA_WIDTH  selected product half
- wr_reg_o  out  REGISTER_WIDTH  destination of the result

Behaviour:
- Reset (rst_ni low, asynchronous): all stage valid bits, results and wr_regs are 0. As a result, every output is 0.
- Accept: an op is accepted on a rising edge when valid_i=1, stall_i=0 and flush_i=0. No backpressure is given to the issuer; the issuer must honour stall_i.
- Stage 1 captures the mode-selected result from a single multiply:
  - Operands are extended to DATA_WIDTH+1 bits: a is sign-extended for MULH/MULHSU, b is sign-extended for MULH only; otherwise zero-extended.
  - The extended operands are multiplied as signed, giving a 2*DATA_WIDTH product.
  - MUL takes product[DATA_WIDTH-1:0]; the other modes take product[2*DATA_WIDTH-1:DATA_WIDTH].
- Stages 2..NUM_STAGES shift {valid, wr_reg, result} forward by one stage per unstalled cycle.
- result_valid_o, result_o and wr_reg_o are driven directly from stage NUM_STAGES.
- Latency: the op accepted at edge t is visible on the outputs in the cycle after edge t+NUM_STAGES-1, i.e. NUM_STAGES edges after issue.
- Issue rate: a result is consumed by the writeback stage on any edge where stall_i=0. Full throughput is one op per cycle.
- stall_i=1: every stage, including the output stage, holds its contents. The outputs hold steady and result_valid_o stays high if it was high. No duplication, no loss.
- flush_i=1: all valid bits clear on the next edge. flush_i has priority over stall_i and over a simultaneous valid_i, whose op is discarded.
- wb_is_next_cycle_o = stage NUM_STAGES-1 valid & !stall_i & !flush_i.
- busy_o = OR of all stage valid bits.
- hazard_o (combinational) = check_reg_i != 0 AND some valid stage 1..NUM_STAGES holds wr_reg == check_reg_i. An op still in the output stage counts as a hazard. The incoming valid_i op is not checked.
- Result writes to register 0 flow through normally; suppression is the writeback stage's job.
- Reset asserted mid-operation: all in-flight ops are dropped immediately.

Optional Feature:
- Macro: MUL_DEBUG_TRACE_EN.
- Defined:
  - Adds inputs debug_pc_i [ADDR_WIDTH] and debug_instr_i (instruction_t).
  - Adds outputs debug_pc_o and debug_instr_o.
  - The debug fields are carried through every stage with the same stall/flush/reset rules.
  - They are aligned with result_o and reset to 0.
- Undefined: these ports and registers do not exist; no other behaviour changes.

Decomposition:
- params_pkg gets:
  - mul_mode_e (MUL_LO=2'b00, MUL_HSS=2'b01, MUL_HSU=2'b10, MUL_HUU=2'b11);
  - mul_stage_t struct {valid, wr_reg, result, debug fields under macro};
  - constant MUL_MAX_STAGES=8.
- One sub-module, mul_pipe_stage: a single mul_stage_t register with stall/flush/async reset.
- mul_pipe instantiates NUM_STAGES copies of mul_pipe_stage via generate, plus the front-end multiply and mode mux.
- An elaboration-time assertion rejects NUM_STAGES outside 2..8.

Test Plan:
- Reset: drive rst_ni=0 mid-stream with 3 ops in flight -> all outputs 0 immediately. After release, no stale result appears.
- Back-to-back MUL, NUM_STAGES=5: 3*5 then 7*-2 on consecutive edges -> result_o=15 then 0xFFFFFFF2 on consecutive cycles, 5 edges after each issue. wb_is_next_cycle_o is high one cycle before each.
- Modes, DATA_WIDTH=32:
  - MULH 0x80000000*0x80000000 -> 0x40000000;
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF;
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- Stall: stall_i=1 for 3 cycles while 2 ops are in flight, one of them in the output stage -> each result appears exactly once, delayed 3 cycles, and the outputs are stable during the stall.
- Flush: 4 ops in flight plus flush_i=1 with valid_i=1 on the same edge -> busy_o=0 next cycle and no result_valid_o ever. An op issued the following cycle completes normally.
- Hazard:
  - issue wr_reg=7, drive check_reg_i=7 -> hazard_o=1 from the cycle after issue through the result cycle, then 0;
  - check_reg_i=0 with a wr_reg=0 op in flight -> hazard_o=0.
